// File: rtl/reg_file_mp_pkg.sv
// rtl/reg_file_mp_pkg.sv - shared constants and types for the multi-port register file
package rf_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NREGS      = 2 ** ADDR_W_DEF;

    typedef logic [NREGS-1:0] pend_vec_t;
endpackage

// File: rtl/reg_file_mp_if.sv
// rtl/reg_file_mp_if.sv - read/write/pending/debug bus of the multi-port register file
interface reg_file_mp_if
    import rf_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = 2
);
    logic [NUM_RD*ADDR_W-1:0] RF_rd_addr;
    logic [NUM_RD*DATA_W-1:0] RF_rd_data;
    logic [NUM_RD-1:0]        RF_rd_busy;
    logic                     RF_wr_en;
    logic [ADDR_W-1:0]        RF_wr_addr;
    logic [DATA_W-1:0]        RF_wr_data;
    logic                     RF_pend_set;
    logic [ADDR_W-1:0]        RF_pend_addr;
    logic [ADDR_W-1:0]        RF_dbg_addr;
    logic [DATA_W-1:0]        RF_dbg_data;
    logic                     RF_any_pend;

    modport master (
        output RF_rd_addr, RF_wr_en, RF_wr_addr, RF_wr_data,
        output RF_pend_set, RF_pend_addr, RF_dbg_addr,
        input  RF_rd_data, RF_rd_busy, RF_dbg_data, RF_any_pend
    );

    modport slave (
        input  RF_rd_addr, RF_wr_en, RF_wr_addr, RF_wr_data,
        input  RF_pend_set, RF_pend_addr, RF_dbg_addr,
        output RF_rd_data, RF_rd_busy, RF_dbg_data, RF_any_pend
    );
endinterface

// File: rtl/reg_file_mp_scoreboard.sv
// rtl/reg_file_mp_scoreboard.sv - per-register pending bits for outstanding multi-cycle loads
module rf_scoreboard #(
    parameter int ADDR_W = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic [ADDR_W-1:0]       clr_addr,
    input  logic                    set,
    input  logic [ADDR_W-1:0]       set_addr,
    output logic [(1<<ADDR_W)-1:0]  pend,
    output logic                    any_pend
);
    logic [(1<<ADDR_W)-1:0] pend_nxt;

    // Set is applied after clear so a newer load wins over a same-cycle writeback
    always_comb begin
        pend_nxt = pend;
        if (clr) pend_nxt[clr_addr] = 1'b0;
        if (set) pend_nxt[set_addr] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pend <= '0;
        else        pend <= pend_nxt;
    end

    assign any_pend = |pend;
endmodule

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - parametrised multi-read-port register file with bypass, scoreboard and debug port
module reg_file_mp
    import rf_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic          RF_clk,
    input  logic          RF_reset_n,
    reg_file_mp_if.slave  bus
);
    localparam int NUM_REGS = 1 << ADDR_W;

    logic [DATA_W-1:0]   mem [NUM_REGS];
    logic [NUM_REGS-1:0] pend;
    logic                wr_ok;
    logic                set_ok;
    logic [DATA_W-1:0]   dbg_q;

    // Register 0 swallows writes and pending-sets when it is hardwired to zero
    assign wr_ok  = bus.RF_wr_en    && !((ZERO_REG != 0) && (bus.RF_wr_addr   == '0));
    assign set_ok = bus.RF_pend_set && !((ZERO_REG != 0) && (bus.RF_pend_addr == '0));

    always_ff @(posedge RF_clk or negedge RF_reset_n) begin
        if (!RF_reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
        end else if (wr_ok) begin
            mem[bus.RF_wr_addr] <= bus.RF_wr_data;
        end
    end

    always_ff @(posedge RF_clk or negedge RF_reset_n) begin
        if (!RF_reset_n)
            dbg_q <= '0;
        else if ((ZERO_REG != 0) && (bus.RF_dbg_addr == '0))
            dbg_q <= '0;
        else
            dbg_q <= mem[bus.RF_dbg_addr];
    end

    assign bus.RF_dbg_data = dbg_q;

    rf_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
        .clk      (RF_clk),
        .rst_n    (RF_reset_n),
        .clr      (wr_ok),
        .clr_addr (bus.RF_wr_addr),
        .set      (set_ok),
        .set_addr (bus.RF_pend_addr),
        .pend     (pend),
        .any_pend (bus.RF_any_pend)
    );

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic              is_zero;
        logic              hit;

        assign addr    = bus.RF_rd_addr[g*ADDR_W +: ADDR_W];
        assign is_zero = (ZERO_REG != 0) && (addr == '0);
        assign hit     = (BYPASS != 0) && bus.RF_wr_en && (addr == bus.RF_wr_addr);

        assign bus.RF_rd_data[g*DATA_W +: DATA_W] = is_zero ? '0 :
                                                    hit     ? bus.RF_wr_data : mem[addr];
        assign bus.RF_rd_busy[g] = !is_zero && pend[addr] && !hit;
    end
endmodule
